bidir_ch_ctrl: RTL and testbench

- Per-end direction controller for one bidirectional inter-router channel.
- One instance sits at each end of a link and sequences which end drives the shared wires.
- Ownership passes between the ends as a token via a req/rel handshake, with a turnaround gap and a bounded hold for fairness.
- The router's output arbiter uses send_en to qualify grants onto this channel.

---
 rtl/bidir_ch_ctrl_pkg.sv | 25 ++
 rtl/bidir_ch_ctrl_if.sv | 33 +++
 rtl/bidir_ch_ctrl_sat_cnt.sv | 25 ++
 rtl/bidir_ch_ctrl.sv | 103 ++++++++++
 tb/tb_bidir_ch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bidir_ch_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the bidirectional channel direction controller.
// Optional statistics counters are enabled by defining BIDIR_STATS_EN.
package bidir_pkg;

  typedef enum logic [2:0] {
    CH_IN   = 3'd0,
    CH_REQ  = 3'd1,
    CH_TURN = 3'd2,
    CH_OUT  = 3'd3,
    CH_REL  = 3'd4
  } ch_state_t;

  localparam int TURN_W = 4;
  localparam int WDOG_W = 10;

  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // Longest a healthy link can leave both ends requesting before the token must have moved.
  function automatic int wdog_limit(input int max_hold, input int turn_cyc);
    return 2 * (max_hold + turn_cyc + 8);
  endfunction

endpackage

// File: rtl/bidir_ch_ctrl_if.sv
// Handshake and status bundle between a router port and its channel direction controller.
// The stats outputs exist only when BIDIR_STATS_EN is defined.
interface bidir_ch_ctrl_if;
  logic local_req;
  logic pkt_active;
  logic req_i;
  logic rel_i;
  logic req_o;
  logic rel_o;
  logic dir_out;
  logic send_en;
  logic err_o;
`ifdef BIDIR_STATS_EN
  logic [15:0] xfer_cnt;
  logic [15:0] own_cyc;
`endif

  modport slave (
    input  local_req, pkt_active, req_i, rel_i,
    output req_o, rel_o, dir_out, send_en, err_o
`ifdef BIDIR_STATS_EN
    , output xfer_cnt, own_cyc
`endif
  );

  modport master (
    output local_req, pkt_active, req_i, rel_i,
    input  req_o, rel_o, dir_out, send_en, err_o
`ifdef BIDIR_STATS_EN
    , input xfer_cnt, own_cyc
`endif
  );
endinterface

// File: rtl/bidir_ch_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; shared by the hold, turnaround,
// watchdog and statistics counters of bidir_ch_ctrl.
module sat_cnt #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bidir_ch_ctrl.sv
// Per-end direction controller for one bidirectional inter-router channel: passes the
// drive token via req/rel with a turnaround gap and bounded hold. BIDIR_STATS_EN adds counters.
module bidir_ch_ctrl
  import bidir_pkg::*;
#(
  parameter bit HIGH_PRIO = 1'b0,
  parameter int MAX_HOLD  = 8,
  parameter int TURN_CYC  = 2
) (
  input logic            clk,
  input logic            rst,
  bidir_ch_ctrl_if.slave ch
);

  localparam logic [2:0] S_IN   = CH_IN;
  localparam logic [2:0] S_REQ  = CH_REQ;
  localparam logic [2:0] S_TURN = CH_TURN;
  localparam logic [2:0] S_OUT  = CH_OUT;
  localparam logic [2:0] S_REL  = CH_REL;

  localparam int                HOLD_W     = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LAST  = TURN_W'(TURN_CYC - 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(wdog_limit(MAX_HOLD, TURN_CYC));
  localparam logic [2:0]        RST_STATE  = HIGH_PRIO ? S_OUT : S_IN;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_cond;
  logic              proto_err;

  // Hold counter is zero outside S_OUT, which gives the clear-on-entry behaviour for free.
  sat_cnt #(.WIDTH(HOLD_W), .MAX(HOLD_MAX)) u_hold (
    .clk(clk), .rst(rst), .clr(state != S_OUT), .inc(ch.req_i), .cnt(hold_cnt)
  );

  sat_cnt #(.WIDTH(TURN_W)) u_turn (
    .clk(clk), .rst(rst), .clr(state != S_TURN), .inc(1'b1), .cnt(turn_cnt)
  );

  assign wdog_cond = (state == S_REQ) && ch.req_i && ch.req_o;

  sat_cnt #(.WIDTH(WDOG_W)) u_wdog (
    .clk(clk), .rst(rst), .clr(!wdog_cond), .inc(1'b1), .cnt(wdog_cnt)
  );

  assign proto_err = (ch.rel_i && (state == S_OUT || state == S_TURN || state == S_REL))
                  || (wdog_cond && wdog_cnt == WDOG_LIMIT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IN: begin
        if (ch.rel_i)          state_nxt = S_TURN;
        else if (ch.local_req) state_nxt = S_REQ;
      end
      S_REQ:  if (ch.rel_i) state_nxt = S_TURN;
      S_TURN: if (turn_cnt == TURN_LAST) state_nxt = S_OUT;
      S_OUT: begin
        // An in-flight packet always blocks release so packets are never split.
        if (ch.req_i && !ch.pkt_active && (!ch.local_req || hold_cnt == HOLD_MAX))
          state_nxt = S_REL;
      end
      S_REL:   state_nxt = ch.local_req ? S_REQ : S_IN;
      default: state_nxt = S_IN;
    endcase
  end

  // Outputs are decoded from the next state so each one leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RST_STATE;
      ch.req_o   <= 1'b0;
      ch.rel_o   <= 1'b0;
      ch.dir_out <= HIGH_PRIO;
      ch.send_en <= HIGH_PRIO;
      ch.err_o   <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch.req_o   <= (state_nxt == S_REQ);
      ch.rel_o   <= (state_nxt == S_REL);
      ch.dir_out <= (state_nxt == S_OUT);
      ch.send_en <= (state_nxt == S_OUT);
      ch.err_o   <= ch.err_o | proto_err;
    end
  end

`ifdef BIDIR_STATS_EN
  sat_cnt #(.WIDTH(16)) u_xfer (
    .clk(clk), .rst(rst), .clr(1'b0),
    .inc(state == S_TURN && state_nxt == S_OUT), .cnt(ch.xfer_cnt)
  );

  sat_cnt #(.WIDTH(16)) u_own (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(state == S_OUT), .cnt(ch.own_cyc)
  );
`endif

endmodule

// File: tb/tb_bidir_ch_ctrl.sv
// Self-checking bench for bidir_ch_ctrl: two ends checked every cycle against a token-level
// model, directed scenarios with literal expectations, then linked and solo random traffic.
module tb_bidir_ch_ctrl;

  localparam int MAX_HOLD = 8;
  localparam int TURN_CYC = 2;
  localparam int WD_LIMIT = 2 * (MAX_HOLD + TURN_CYC + 8);
  localparam int PERIOD   = 2 * (MAX_HOLD + TURN_CYC + 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  bit   link = 1'b0;
  logic a_lr = 0, a_pa = 0, a_rq = 0, a_rl = 0;
  logic b_lr = 0, b_pa = 0, b_rq = 0, b_rl = 0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bidir_ch_ctrl_if ifa ();
  bidir_ch_ctrl_if ifb ();

  assign ifa.local_req  = a_lr;
  assign ifa.pkt_active = a_pa;
  assign ifa.req_i      = link ? ifb.req_o : a_rq;
  assign ifa.rel_i      = link ? ifb.rel_o : a_rl;
  assign ifb.local_req  = b_lr;
  assign ifb.pkt_active = b_pa;
  assign ifb.req_i      = link ? ifa.req_o : b_rq;
  assign ifb.rel_i      = link ? ifa.rel_o : b_rl;

  bidir_ch_ctrl #(.HIGH_PRIO(1'b0), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) u_a (
    .clk(clk), .rst(rst), .ch(ifa)
  );
  bidir_ch_ctrl #(.HIGH_PRIO(1'b1), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) u_b (
    .clk(clk), .rst(rst), .ch(ifb)
  );

  // Token-level view of one end: who drives, whether a turnaround or release is in progress.
  typedef struct {
    bit own;
    bit gap;
    int gap_n;
    bit ask;
    bit rel;
    int hold;
    int wd;
    bit err;
  } m_t;

  m_t ma, mb;

  function automatic m_t m_reset(input bit prio);
    m_t m;
    m = '{default: 0};
    m.own = prio;
    return m;
  endfunction

  function automatic m_t step(input m_t m, input bit lr, input bit pa, input bit rq, input bit rl);
    m_t n;
    n = m;
    n.rel = 1'b0;
    if (rl && (m.own || m.gap || m.rel)) n.err = 1'b1;
    if (m.ask && rq) begin
      if (m.wd == WD_LIMIT) n.err = 1'b1;
      n.wd = m.wd + 1;
    end else begin
      n.wd = 0;
    end
    if (m.own) begin
      if (rq && !pa && (!lr || m.hold == MAX_HOLD)) begin
        n.own = 1'b0; n.rel = 1'b1; n.hold = 0;
      end else if (rq && m.hold < MAX_HOLD) begin
        n.hold = m.hold + 1;
      end
    end else if (m.gap) begin
      if (m.gap_n == TURN_CYC - 1) begin
        n.gap = 1'b0; n.own = 1'b1; n.hold = 0;
      end else begin
        n.gap_n = m.gap_n + 1;
      end
    end else if (m.rel) begin
      n.ask = lr;
    end else if (rl) begin
      n.ask = 1'b0; n.gap = 1'b1; n.gap_n = 0;
    end else if (lr) begin
      n.ask = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      ma = m_reset(1'b0);
      mb = m_reset(1'b1);
    end else begin
      ma = step(ma, ifa.local_req, ifa.pkt_active, ifa.req_i, ifa.rel_i);
      mb = step(mb, ifb.local_req, ifb.pkt_active, ifb.req_i, ifb.rel_i);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a.req_o",   ifa.req_o,   ma.ask);
      check("a.rel_o",   ifa.rel_o,   ma.rel);
      check("a.dir_out", ifa.dir_out, ma.own);
      check("a.send_en", ifa.send_en, ma.own);
      check("a.err_o",   ifa.err_o,   ma.err);
      check("b.req_o",   ifb.req_o,   mb.ask);
      check("b.rel_o",   ifb.rel_o,   mb.rel);
      check("b.dir_out", ifb.dir_out, mb.own);
      check("b.send_en", ifb.send_en, mb.own);
      check("b.err_o",   ifb.err_o,   mb.err);
      if (link) check("link single driver", ifa.dir_out & ifb.dir_out, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a_rel();
    a_rl = 1'b1;
    tick(1);
    a_rl = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  initial begin
    int last, nacq;
    bit prev;

    // Reset state of both ends
    tick(2);
    chk_en = 1'b1;
    rst = 1'b1;
    check("rst a.dir_out", ifa.dir_out, 0);
    check("rst a.req_o",   ifa.req_o,   0);
    check("rst b.dir_out", ifb.dir_out, 1);
    check("rst b.send_en", ifb.send_en, 1);
    check("rst a.err_o",   ifa.err_o,   0);

    // Request, token arrival, TURN_CYC+1 latency to first send_en
    tick(3);
    a_lr = 1'b1;
    tick(1);
    check("t1 req_o", ifa.req_o, 1);
    tick(2);
    pulse_a_rel();
    check("t1 send_en +1", ifa.send_en, 0);
    tick(1);
    check("t1 send_en +2", ifa.send_en, 0);
    tick(1);
    check("t1 send_en +3", ifa.send_en, 1);

    // Idle owner releases one cycle after peer request
    b_lr = 1'b0;
    b_rq = 1'b1;
    tick(1);
    check("t2 rel_o",   ifb.rel_o,   1);
    check("t2 dir_out", ifb.dir_out, 0);
    b_rq = 1'b0;
    tick(1);
    check("t2 rel_o end", ifb.rel_o, 0);
    check("t2 in idle",   ifb.req_o, 0);

    // Busy owner holds for MAX_HOLD counted cycles, then re-requests
    a_rq = 1'b1;
    tick(MAX_HOLD);
    check("t3 rel_o early", ifa.rel_o, 0);
    tick(1);
    check("t3 rel_o", ifa.rel_o, 1);
    a_rq = 1'b0;
    tick(1);
    check("t3 req_o", ifa.req_o, 1);

    // Saturated owner held by an active packet
    pulse_a_rel();
    tick(2);
    check("t4 owner", ifa.dir_out, 1);
    a_rq = 1'b1;
    a_pa = 1'b1;
    tick(MAX_HOLD + 5);
    check("t4 rel blocked", ifa.rel_o,   0);
    check("t4 still owns",  ifa.dir_out, 1);
    a_pa = 1'b0;
    tick(1);
    check("t4 rel_o", ifa.rel_o, 1);
    a_rq = 1'b0;
    tick(1);

    // Watchdog: stuck in S_REQ with peer also requesting
    a_rq = 1'b1;
    tick(WD_LIMIT);
    check("wdog not yet", ifa.err_o, 0);
    tick(1);
    check("wdog err", ifa.err_o, 1);
    a_rq = 1'b0;
    do_reset();
    check("wdog cleared", ifa.err_o, 0);

    // rel_i while owning is a sticky error
    tick(1);
    pulse_a_rel();
    tick(2);
    check("t6 owner", ifa.dir_out, 1);
    pulse_a_rel();
    check("t6 err", ifa.err_o, 1);
    tick(5);
    check("t6 err sticky", ifa.err_o, 1);

    // Reset in the middle of a turnaround aborts it
    do_reset();
    a_lr = 1'b0;
    pulse_a_rel();
    do_reset();
    check("t6 rst dir",  ifa.dir_out, 0);
    check("t6 rst req",  ifa.req_o,   0);
    check("t6 rst err",  ifa.err_o,   0);
    tick(3);
    check("t6 turn aborted", ifa.send_en, 0);

    // Linked pair, both always busy: strict alternation
    a_lr = 1'b1;
    b_lr = 1'b1;
    a_pa = 1'b0;
    b_pa = 1'b0;
    link = 1'b1;
    do_reset();
    last = -1;
    nacq = 0;
    prev = ifa.dir_out;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      tick(1);
      if (ifa.dir_out && !prev) begin
        nacq++;
        if (last >= 0) check("link period", cyc - last, PERIOD);
        last = cyc;
      end
      prev = ifa.dir_out;
    end
    check("link acquisitions", nacq >= 7, 1);
    check("link a.err_o", ifa.err_o, 0);
    check("link b.err_o", ifb.err_o, 0);

    // Linked pair, random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      a_lr = ($urandom % 4) != 0;
      b_lr = ($urandom % 3) != 0;
      if ($urandom % 6 == 0) a_pa = ~a_pa;
      if ($urandom % 6 == 0) b_pa = ~b_pa;
      tick(1);
    end

    // Solo ends, random peer behaviour including illegal releases
    link = 1'b0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      a_lr = $urandom % 2;
      b_lr = $urandom % 2;
      a_pa = ($urandom % 5) == 0;
      b_pa = ($urandom % 5) == 0;
      if ($urandom % 8 == 0) a_rq = ~a_rq;
      if ($urandom % 8 == 0) b_rq = ~b_rq;
      a_rl = ($urandom % 16) == 0;
      b_rl = ($urandom % 16) == 0;
      tick(1);
      if (i % 300 == 299) do_reset();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
